pi_digit_stream: RTL and testbench

Downstream consumer of the pi series accumulator's `sum` vector. It snapshots the radix-1000 limb vector, converts each 10-bit limb to three BCD digits with a fixed-latency shift-add-3 (double-dabble) converter, and streams the digits most-significant first over a valid/ready handshake. The digits feed the VGA text-buffer writer, and each digit is tagged with its screen position.

---
 rtl/pi_digit_stream.sv | 167 ++++++++++++++++
 tb/tb_pi_digit_stream.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pi_digit_stream.sv
// Snapshots a radix-1000 limb vector, converts each limb to three BCD digits
// with a serial double-dabble converter and streams them out MSD first.
module pi_digit_stream #(
    parameter int L = 10,
    parameter int N = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [L*N-1:0] sum_in,
    output logic           busy,
    output logic           done,
    output logic           dig_valid,
    input  logic           dig_ready,
    output logic [3:0]     dig,
    output logic [7:0]     dig_addr,
    output logic           dig_point,
    output logic           err
);
    localparam int IW = (L > 1) ? $clog2(L) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CONV, EMIT, DONE} state_t;

    state_t         state_reg, state_next;
    logic [L*N-1:0] shadow_reg;
    logic [IW-1:0]  limb_idx_reg;
    logic [N-1:0]   shift_reg;
    logic [15:0]    bcd_reg;
    logic [15:0]    bcd_adj;
    logic [15:0]    bcd_next;
    logic [CW-1:0]  cnt_reg;
    logic [1:0]     slot_reg;
    logic [3:0]     dig_reg;
    logic [7:0]     dig_addr_reg;
    logic           dig_point_reg;
    logic           dig_valid_reg;
    logic           busy_reg;
    logic           done_reg;
    logic           err_reg;
    logic           xfer;
    logic           conv_last;

    assign xfer      = dig_valid_reg && dig_ready;
    assign conv_last = (cnt_reg == CW'(N - 1));

    // Add-3 correction on every nibble, then shift in the next limb bit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 :
                                        bcd_reg[gi*4 +: 4];
        end
    endgenerate
    assign bcd_next = {bcd_adj[14:0], shift_reg[N-1]};

    // A nonzero thousands nibble means the limb was out of radix-1000 range.
    function automatic logic [3:0] pick(input logic [15:0] bcd, input logic [1:0] slot);
        logic [3:0] d;
        if (bcd[15:12] != 4'd0) begin
            d = 4'hF;
        end else begin
            case (slot)
                2'd0:    d = bcd[11:8];
                2'd1:    d = bcd[7:4];
                default: d = bcd[3:0];
            endcase
        end
        return d;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = CONV;
            CONV: if (conv_last) state_next = EMIT;
            EMIT: begin
                if (xfer && slot_reg == 2'd2) begin
                    state_next = (limb_idx_reg == '0) ? DONE : CONV;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_reg    <= '0;
            limb_idx_reg  <= '0;
            shift_reg     <= '0;
            bcd_reg       <= '0;
            cnt_reg       <= '0;
            slot_reg      <= '0;
            dig_reg       <= '0;
            dig_addr_reg  <= '0;
            dig_point_reg <= 1'b0;
            dig_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            dig_valid_reg <= (state_next == EMIT);
            done_reg      <= (state_next == DONE);
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shadow_reg    <= sum_in;
                        shift_reg     <= sum_in[N*(L-1) +: N];
                        limb_idx_reg  <= IW'(L - 1);
                        bcd_reg       <= '0;
                        cnt_reg       <= '0;
                        dig_addr_reg  <= '0;
                        dig_point_reg <= 1'b0;
                        err_reg       <= 1'b0;
                        busy_reg      <= 1'b1;
                    end
                end
                CONV: begin
                    shift_reg <= {shift_reg[N-2:0], 1'b0};
                    bcd_reg   <= bcd_next;
                    cnt_reg   <= conv_last ? '0 : cnt_reg + 1'b1;
                    if (conv_last) begin
                        slot_reg <= 2'd0;
                        dig_reg  <= pick(bcd_next, 2'd0);
                        if (bcd_next[15:12] != 4'd0) err_reg <= 1'b1;
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        dig_addr_reg  <= dig_addr_reg + 8'd1;
                        dig_point_reg <= (dig_addr_reg + 8'd1 == 8'd3);
                        if (slot_reg != 2'd2) begin
                            slot_reg <= slot_reg + 2'd1;
                            dig_reg  <= pick(bcd_reg, slot_reg + 2'd1);
                        end else if (limb_idx_reg != '0) begin
                            // Shadow shifts up so the next limb is always just below the top.
                            limb_idx_reg <= limb_idx_reg - 1'b1;
                            shift_reg    <= shadow_reg[N*(L-1)-1 -: N];
                            shadow_reg   <= {shadow_reg[N*(L-1)-1:0], {N{1'b0}}};
                            bcd_reg      <= '0;
                            cnt_reg      <= '0;
                        end
                    end
                end
                DONE: busy_reg <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign dig_valid = dig_valid_reg;
    assign dig       = dig_reg;
    assign dig_addr  = dig_addr_reg;
    assign dig_point = dig_point_reg;
    assign err       = err_reg;
endmodule

// File: tb/tb_pi_digit_stream.sv
// Directed bench for pi_digit_stream: expected digits come from a limb-to-BCD
// model queued at start and compared whenever the DUT presents a digit.
module tb_pi_digit_stream;
    localparam int L = 10;
    localparam int N = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [L*N-1:0] sum_in;
    logic           busy;
    logic           done;
    logic           dig_valid;
    logic           dig_ready;
    logic [3:0]     dig;
    logic [7:0]     dig_addr;
    logic           dig_point;
    logic           err;

    pi_digit_stream #(.L(L), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sum_in    (sum_in),
        .busy      (busy),
        .done      (done),
        .dig_valid (dig_valid),
        .dig_ready (dig_ready),
        .dig       (dig),
        .dig_addr  (dig_addr),
        .dig_point (dig_point),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       point;
        logic [7:0] addr;
        logic [3:0] dig;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   pi_limbs[L] = '{3, 141, 592, 653, 589, 793, 238, 462, 643, 383};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_pi();
        for (int i = 0; i < L; i++) sum_in[N*(L-1-i) +: N] = N'(pi_limbs[i]);
    endtask

    task automatic push_expected(input logic [L*N-1:0] v);
        int   a;
        int   limb;
        exp_t e;
        a = 0;
        for (int k = L - 1; k >= 0; k--) begin
            limb = int'(v[N*k +: N]);
            for (int s = 0; s < 3; s++) begin
                if (limb > 999)  e.dig = 4'hF;
                else if (s == 0) e.dig = 4'(limb / 100);
                else if (s == 1) e.dig = 4'((limb / 10) % 10);
                else             e.dig = 4'(limb % 10);
                e.addr  = 8'(a);
                e.point = (a == 3);
                sb.push_back(e);
                a++;
            end
        end
    endtask

    // mode 0: ready held high; mode 1: ready toggles and drops for 5 cycles.
    task automatic run_stream(input int mode, input bit perturb,
                              output int done_n, output int first_v, output logic err_at_done);
        int n;
        bit seen;
        bit bad;
        seen = 0; bad = 0; done_n = -1; first_v = -1; err_at_done = 1'bx;
        @(posedge clk); #1;
        start = 1'b1;
        dig_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!seen && n < 3000) begin
            @(negedge clk);
            if (n == 0) begin
                check("busy_after_start", 32'(busy), 32'd1);
                check("err_cleared_on_start", 32'(err), 32'd0);
            end
            if (dig_valid) begin
                if (first_v < 0) first_v = n;
                if (sb.size() == 0) begin
                    check("extra_digit_addr", 32'(dig_addr), 32'hFFFF_FFFF);
                end else begin
                    if (sb[0].dig == 4'hF) bad = 1;
                    check("dig", 32'(dig), 32'(sb[0].dig));
                    check("dig_addr", 32'(dig_addr), 32'(sb[0].addr));
                    check("dig_point", 32'(dig_point), 32'(sb[0].point));
                    check("err_live", 32'(err), 32'(bad));
                    if (dig_ready) void'(sb.pop_front());
                end
            end
            if (done) begin
                seen = 1;
                done_n = n;
                err_at_done = err;
            end
            @(posedge clk);
            n++;
            #1;
            if (mode == 0) dig_ready = 1'b1;
            else           dig_ready = (n % 2 == 0) && !(n >= 40 && n < 45);
            if (perturb && n == 50) begin
                sum_in = '1;
                start = 1'b1;
            end
            if (perturb && n == 51) start = 1'b0;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("queue_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    int   dn, fv, n;
    logic ead;

    initial begin
        rst = 1'b1; start = 1'b0; dig_ready = 1'b0; sum_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(dig_valid), 32'd0);
        check("rst_dig", 32'(dig), 32'd0);
        check("rst_addr", 32'(dig_addr), 32'd0);
        check("rst_point", 32'(dig_point), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // pi digits, no backpressure: fixed latency
        load_pi();
        push_expected(sum_in);
        run_stream(0, 0, dn, fv, ead);
        check("first_valid_cycle", 32'(fv), 32'd10);
        check("done_cycle", 32'(dn), 32'(13 * L));
        check("err_at_done_pi", 32'(ead), 32'd0);

        // same vector under backpressure
        load_pi();
        push_expected(sum_in);
        run_stream(1, 0, dn, fv, ead);
        check("err_at_done_bp", 32'(ead), 32'd0);

        // out-of-range limb right after a 999 limb
        load_pi();
        sum_in[N*5 +: N] = 10'd999;
        sum_in[N*4 +: N] = 10'd1000;
        push_expected(sum_in);
        run_stream(0, 0, dn, fv, ead);
        check("err_at_done_oor", 32'(ead), 32'd1);
        check("done_cycle_oor", 32'(dn), 32'(13 * L));

        // next start clears err
        load_pi();
        push_expected(sum_in);
        run_stream(0, 0, dn, fv, ead);
        check("err_after_restart", 32'(ead), 32'd0);

        // all zero, input disturbed and start pulsed mid-stream
        sum_in = '0;
        push_expected(sum_in);
        run_stream(0, 1, dn, fv, ead);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("no_second_done", 32'(done), 32'd0);
            check("idle_no_valid", 32'(dig_valid), 32'd0);
        end

        // reset while stalled at addr 17
        load_pi();
        @(posedge clk); #1;
        start = 1'b1;
        dig_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (n < 77) begin
            @(posedge clk);
            n++;
            #1;
        end
        dig_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(dig_valid), 32'd1);
            check("stall_addr", 32'(dig_addr), 32'd17);
            check("stall_dig", 32'(dig), 32'd3);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(dig_valid), 32'd0);
        check("arst_addr", 32'(dig_addr), 32'd0);
        check("arst_dig", 32'(dig), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_point", 32'(dig_point), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        dig_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", 32'(dig_valid), 32'd0);
            check("post_rst_idle", 32'(busy), 32'd0);
        end
        push_expected(sum_in);
        run_stream(0, 0, dn, fv, ead);
        check("done_cycle_after_rst", 32'(dn), 32'(13 * L));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
